// File: rtl/rs_encoder_arbiter.sv
// rs_encoder_arbiter: round-robin sharing of one RS encoder between packet sources, with output tagging and phase checking
module rs_encoder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SYM_W   = 8,
  parameter int PKT_LEN = 16,
  parameter int CH_W    = $clog2(N_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*SYM_W-1:0]   req_data,
  output logic [N_REQ-1:0]         req_pop,
  output logic [N_REQ-1:0]         grant,
  input  logic                     encoderReadyPort,
  input  logic                     encoderValidPort,
  output logic [SYM_W-1:0]         encoderInputPort,
  input  logic [SYM_W-1:0]         dataOutputPort,
  output logic                     out_valid,
  output logic [SYM_W-1:0]         out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_last,
  output logic                     protocol_error
);
  localparam int CW = $clog2(PKT_LEN + 2);
  localparam logic [CW-1:0] LEN  = CW'(PKT_LEN);
  localparam logic [CW-1:0] MAXC = CW'(PKT_LEN + 1);
  typedef enum logic [1:0] {UNSYNC, RUN, HALT} st_t;
  st_t              st_q;
  logic             err_q, err_d, bad, prim_q, valid_q, ready_q, rise, chg, emit;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] feed_q, feed_d, drain_q, drain_e;
  logic [CH_W-1:0]  ptr_q, ptr_d, idx;
  logic [SYM_W-1:0] sym, out_data_q;
  logic [CH_W-1:0]  out_chan_q;
  logic             out_valid_q, out_last_q;

  function automatic logic [CH_W-1:0] chan_of(input logic [N_REQ-1:0] g);
    chan_of = '0;
    for (int i = 0; i < N_REQ; i++) if (g[i]) chan_of = chan_of | CH_W'(i);
  endfunction

  assign rise    = encoderValidPort & ~valid_q;
  assign chg     = encoderValidPort ^ valid_q;
  assign cnt_d   = chg ? CW'(1) : cnt_q == MAXC ? cnt_q : cnt_q + 1'b1;
  assign bad     = st_q == RUN && (encoderReadyPort == encoderValidPort || (chg && cnt_q != LEN) || cnt_d > LEN);
  assign err_d   = err_q | bad;
  assign drain_e = rise ? feed_q : drain_q;
  assign emit    = encoderValidPort & |drain_e & ~err_d;

  assign grant            = err_q ? '0 : feed_q;
  assign req_pop          = encoderReadyPort ? grant : '0;
  assign encoderInputPort = encoderReadyPort ? sym : '0;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_chan         = out_chan_q;
  assign out_last         = out_last_q;
  assign protocol_error   = err_q;

  // Round-robin search starting at ptr; the lowest offset that requests wins
  always_comb begin
    feed_d = '0;
    ptr_d  = ptr_q;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr_q) + k) % N_REQ);
      if (req[idx]) begin
        feed_d      = '0;
        feed_d[idx] = 1'b1;
        ptr_d       = CH_W'((int'(idx) + 1) % N_REQ);
      end
    end
  end

  // Select the granted source's current symbol; zero for an idle packet
  always_comb begin
    sym = '0;
    for (int i = 0; i < N_REQ; i++) if (grant[i]) sym = sym | req_data[i*SYM_W +: SYM_W];
  end

  // Protocol checker: sync on the first phase edge, then police phase lengths until a violation halts it
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q  <= UNSYNC;
      err_q <= 1'b0;
    end else begin
      st_q  <= err_d ? HALT : (st_q == UNSYNC && prim_q && (chg || (encoderReadyPort ^ ready_q))) ? RUN : st_q;
      err_q <= err_d;
    end
  end

  // Phase tracking, arbitration on the valid rising edge, and the tagged output register
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      prim_q      <= 1'b0;
      cnt_q       <= '0;
      feed_q      <= '0;
      drain_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      valid_q     <= encoderValidPort;
      ready_q     <= encoderReadyPort;
      prim_q      <= 1'b1;
      cnt_q       <= cnt_d;
      if (rise) begin
        drain_q <= feed_q;
        feed_q  <= feed_d;
        ptr_q   <= ptr_d;
      end
      out_valid_q <= emit;
      out_last_q  <= emit && cnt_d == LEN;
      if (emit) begin
        out_data_q <= dataOutputPort;
        out_chan_q <= chan_of(drain_e);
      end
    end
  end
endmodule
